// File: rtl/bb_series.sv
// Best-of-N series accumulator fed by per-game results; emits a one-cycle
// summary when a series is decided and immediately starts the next one.
module bb_series #(
  parameter int WINS_NEEDED = 4,
  parameter int MAX_GAMES   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         score_A,
  input  logic [7:0]         score_B,
  input  logic [1:0]         result,
  output logic               out_valid,
  output logic [3:0]         wins_A,
  output logic [3:0]         wins_B,
  output logic [3:0]         draws,
  output logic [3:0]         games,
  output logic signed [11:0] run_diff,
  output logic [1:0]         series_winner,
  output logic               err
);

  // run_diff is 12 b signed, so more than 8 games of 255-run margins could overflow.
  if (WINS_NEEDED < 1 || WINS_NEEDED > 15 || MAX_GAMES < WINS_NEEDED || MAX_GAMES > 8) begin : g_bad_cfg
    $error("bb_series: illegal WINS_NEEDED/MAX_GAMES configuration");
  end

  typedef enum logic {ACCUM = 1'b0, REPORT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [3:0]         acc_a_q, acc_b_q, acc_d_q, acc_g_q;
  logic signed [11:0] acc_r_q;
  logic [3:0]         acc_a_n, acc_b_n, acc_d_n, acc_g_n;
  logic signed [11:0] acc_r_n;
  logic signed [11:0] diff_s;
  logic               legal_s, end_s;
  logic [1:0]         winner_s;

  logic [3:0]         wins_a_q, wins_b_q, draws_q, games_q;
  logic signed [11:0] run_diff_q;
  logic [1:0]         winner_q;
  logic               err_q;

  assign legal_s = in_valid && (result != 2'd3);
  assign diff_s  = $signed({4'd0, score_A}) - $signed({4'd0, score_B});

  // Post-update accumulator values for the current cycle.
  always_comb begin
    acc_a_n = acc_a_q;
    acc_b_n = acc_b_q;
    acc_d_n = acc_d_q;
    acc_g_n = acc_g_q;
    acc_r_n = acc_r_q;
    if (legal_s) begin
      acc_g_n = acc_g_q + 4'd1;
      acc_r_n = acc_r_q + diff_s;
      case (result)
        2'd0:    acc_a_n = acc_a_q + 4'd1;
        2'd1:    acc_b_n = acc_b_q + 4'd1;
        default: acc_d_n = acc_d_q + 4'd1;
      endcase
    end
  end

  assign end_s = legal_s && ((acc_a_n == 4'(WINS_NEEDED)) ||
                             (acc_b_n == 4'(WINS_NEEDED)) ||
                             (acc_g_n == 4'(MAX_GAMES)));

  always_comb begin
    if (acc_a_n > acc_b_n)      winner_s = 2'd0;
    else if (acc_b_n > acc_a_n) winner_s = 2'd1;
    else if (acc_r_n > 12'sd0)  winner_s = 2'd0;
    else if (acc_r_n < 12'sd0)  winner_s = 2'd1;
    else                        winner_s = 2'd2;
  end

  // Accumulators clear on the series-ending edge so a REPORT-cycle game starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_a_q <= 4'd0;
      acc_b_q <= 4'd0;
      acc_d_q <= 4'd0;
      acc_g_q <= 4'd0;
      acc_r_q <= 12'sd0;
    end else if (end_s) begin
      acc_a_q <= 4'd0;
      acc_b_q <= 4'd0;
      acc_d_q <= 4'd0;
      acc_g_q <= 4'd0;
      acc_r_q <= 12'sd0;
    end else begin
      acc_a_q <= acc_a_n;
      acc_b_q <= acc_b_n;
      acc_d_q <= acc_d_n;
      acc_g_q <= acc_g_n;
      acc_r_q <= acc_r_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wins_a_q   <= 4'd0;
      wins_b_q   <= 4'd0;
      draws_q    <= 4'd0;
      games_q    <= 4'd0;
      run_diff_q <= 12'sd0;
      winner_q   <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      wins_a_q   <= end_s ? acc_a_n  : 4'd0;
      wins_b_q   <= end_s ? acc_b_n  : 4'd0;
      draws_q    <= end_s ? acc_d_n  : 4'd0;
      games_q    <= end_s ? acc_g_n  : 4'd0;
      run_diff_q <= end_s ? acc_r_n  : 12'sd0;
      winner_q   <= end_s ? winner_s : 2'd0;
      err_q      <= in_valid && (result == 2'd3);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // REPORT -> REPORT happens when the REPORT-cycle game itself ends a series.
  always_comb begin
    case (state_q)
      ACCUM:   state_d = end_s ? REPORT : ACCUM;
      REPORT:  state_d = end_s ? REPORT : ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    out_valid     = (state_q == REPORT);
    wins_A        = wins_a_q;
    wins_B        = wins_b_q;
    draws         = draws_q;
    games         = games_q;
    run_diff      = run_diff_q;
    series_winner = winner_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_bb_series.sv
// Scoreboard bench for bb_series: a default-parameter instance and a
// WINS_NEEDED=1 / MAX_GAMES=1 instance, with directed hand-computed series.
module tb_bb_series;

  typedef struct packed {
    logic [3:0]         wa;
    logic [3:0]         wb;
    logic [3:0]         dr;
    logic [3:0]         gm;
    logic signed [11:0] rd;
    logic [1:0]         win;
  } sum_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              iv1 = 1'b0, iv2 = 1'b0;
  logic [7:0]        sa1 = 8'd0, sb1 = 8'd0, sa2 = 8'd0, sb2 = 8'd0;
  logic [1:0]        r1 = 2'd0, r2 = 2'd0;
  logic              ov1, ov2, er1, er2;
  logic [3:0]        wa1, wb1, dr1, gm1, wa2, wb2, dr2, gm2;
  logic signed [11:0] rd1, rd2;
  logic [1:0]        sw1, sw2;

  bb_series #(.WINS_NEEDED(4), .MAX_GAMES(7)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .score_A(sa1), .score_B(sb1), .result(r1),
    .out_valid(ov1), .wins_A(wa1), .wins_B(wb1), .draws(dr1), .games(gm1),
    .run_diff(rd1), .series_winner(sw1), .err(er1));

  bb_series #(.WINS_NEEDED(1), .MAX_GAMES(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .score_A(sa2), .score_B(sb2), .result(r2),
    .out_valid(ov2), .wins_A(wa2), .wins_B(wb2), .draws(dr2), .games(gm2),
    .run_diff(rd2), .series_winner(sw2), .err(er2));

  sum_t q1[$];
  sum_t q2[$];
  int   err_pend = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;

  function automatic sum_t mk(int wa, int wb, int dr, int gm, int rd, int win);
    sum_t s;
    s.wa = 4'(wa); s.wb = 4'(wb); s.dr = 4'(dr); s.gm = 4'(gm);
    s.rd = 12'(rd); s.win = 2'(win);
    return s;
  endfunction

  task automatic check_sum(string name, sum_t act, sum_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got A=%0d B=%0d D=%0d G=%0d rd=%0d w=%0d, want A=%0d B=%0d D=%0d G=%0d rd=%0d w=%0d",
               name, act.wa, act.wb, act.dr, act.gm, act.rd, act.win,
               exp.wa, exp.wb, exp.dr, exp.gm, exp.rd, exp.win);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected summaries whenever out_valid is high.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ov1) begin
        if (q1.size() == 0) check_int("dut1_unexpected_out_valid", 1, 0);
        else check_sum("dut1_summary", {wa1, wb1, dr1, gm1, rd1, sw1}, q1.pop_front());
      end else begin
        check_sum("dut1_idle_zero", {wa1, wb1, dr1, gm1, rd1, sw1}, mk(0, 0, 0, 0, 0, 0));
      end
      if (ov2) begin
        if (q2.size() == 0) check_int("dut2_unexpected_out_valid", 1, 0);
        else check_sum("dut2_summary", {wa2, wb2, dr2, gm2, rd2, sw2}, q2.pop_front());
      end
      if (er1) begin
        check_int("dut1_err_expected", (err_pend > 0) ? 1 : 0, 1);
        if (err_pend > 0) err_pend--;
      end
      if (er2) check_int("dut2_err_unexpected", 1, 0);
    end
  end

  task automatic play1(int r, int a, int b);
    iv1 = 1'b1; r1 = 2'(r); sa1 = 8'(a); sb1 = 8'(b);
    @(posedge clk); #1;
    iv1 = 1'b0; r1 = 2'd0; sa1 = 8'd0; sb1 = 8'd0;
  endtask

  task automatic play2(int r, int a, int b);
    iv2 = 1'b1; r2 = 2'(r); sa2 = 8'(a); sb2 = 8'(b);
    @(posedge clk); #1;
    iv2 = 1'b0; r2 = 2'd0; sa2 = 8'd0; sb2 = 8'd0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check_sum("reset_outputs", {wa1, wb1, dr1, gm1, rd1, sw1}, mk(0, 0, 0, 0, 0, 0));
    check_int("reset_out_valid_err", {ov1, er1, ov2, er2}, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    mon_on = 1'b1;

    // Sweep: four A wins by 3.
    repeat (3) play1(0, 5, 2);
    q1.push_back(mk(4, 0, 0, 4, 12, 0));
    play1(0, 5, 2);
    idle(3);

    // Game limit, wins tied, B ahead on runs.
    play1(0, 3, 2); play1(1, 1, 4); play1(0, 3, 2); play1(1, 1, 4);
    play1(2, 2, 2); play1(2, 2, 2);
    q1.push_back(mk(2, 2, 3, 7, -4, 1));
    play1(2, 2, 2);
    idle(3);

    // Game limit, wins tied, A ahead on runs.
    play1(0, 4, 1); play1(1, 0, 1); play1(0, 4, 1); play1(1, 0, 1);
    play1(2, 0, 0); play1(2, 7, 7);
    q1.push_back(mk(2, 2, 3, 7, 4, 0));
    play1(2, 1, 1);
    idle(3);

    // Game limit, everything level: tied series.
    play1(1, 2, 4); play1(0, 4, 2); play1(2, 0, 0); play1(2, 0, 0);
    play1(1, 255, 0 + 255 + 0); play1(0, 9, 9);
    q1.push_back(mk(2, 2, 3, 7, 0, 2));
    play1(2, 3, 3);
    idle(3);

    // Illegal result mid-series is discarded and flagged.
    play1(0, 3, 1); play1(0, 3, 1);
    err_pend++;
    play1(3, 9, 0);
    play1(0, 3, 1);
    q1.push_back(mk(4, 0, 0, 4, 8, 0));
    play1(0, 3, 1);
    idle(3);

    // Back-to-back: a game in the REPORT cycle opens the next series.
    play1(0, 1, 0); play1(0, 1, 0); play1(0, 1, 0);
    q1.push_back(mk(4, 0, 0, 4, 4, 0));
    play1(0, 1, 0);
    play1(1, 0, 9);
    play1(1, 1, 2); play1(1, 1, 2);
    q1.push_back(mk(0, 4, 0, 4, -12, 1));
    play1(1, 1, 2);
    idle(3);

    // Reset mid-series discards the partial series.
    play1(0, 2, 0); play1(0, 2, 0); play1(0, 2, 0);
    rst = 1'b1;
    #1;
    check_sum("mid_reset_outputs", {wa1, wb1, dr1, gm1, rd1, sw1}, mk(0, 0, 0, 0, 0, 0));
    check_int("mid_reset_out_valid", {ov1, er1}, 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    play1(1, 0, 1); play1(1, 0, 1); play1(1, 0, 1);
    q1.push_back(mk(0, 4, 0, 4, -4, 1));
    play1(1, 0, 1);
    idle(3);

    // WINS_NEEDED=1: three consecutive games, three consecutive summaries.
    q2.push_back(mk(1, 0, 0, 1, 1, 0));
    q2.push_back(mk(0, 1, 0, 1, -2, 1));
    q2.push_back(mk(0, 0, 1, 1, 0, 2));
    play2(0, 1, 0);
    play2(1, 0, 2);
    play2(2, 3, 3);
    idle(4);

    check_int("dut1_queue_drained", q1.size(), 0);
    check_int("dut2_queue_drained", q2.size(), 0);
    check_int("err_pulses_seen", err_pend, 0);
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
